// File: rtl/gf_power_sweep_8_pkg.sv
// Shared GF(2^8) constants, sweep FSM encoding and elaboration-time table builders.
// The table builders run only at elaboration; the hardware sees constant ROMs.
package gf8_pkg;

   localparam logic [8:0] GF8_PRIM_POLY = 9'h11D;
   localparam int         GF8_ORDER     = 255;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sweep_state_t;

   typedef logic [255:0][7:0] gf8_tbl_t;

   function automatic logic [7:0] gf8_mul_alpha_f(input logic [7:0] e, input logic [7:0] poly_lo);
      return {e[6:0], 1'b0} ^ (e[7] ? poly_lo : 8'h00);
   endfunction

   // Entry 255 aliases alpha^0 so the ROM is fully defined.
   function automatic gf8_tbl_t gf8_alog_tbl(input logic [7:0] poly_lo);
      gf8_tbl_t   t;
      logic [7:0] e;
      t = '0;
      e = 8'h01;
      for (int k = 0; k < GF8_ORDER; k++) begin
         t[k[7:0]] = e;
         e = gf8_mul_alpha_f(e, poly_lo);
      end
      t[8'hFF] = 8'h01;
      return t;
   endfunction

   // log(0) is undefined; it maps to 8'hFF, a power the sweep never issues.
   function automatic gf8_tbl_t gf8_log_tbl(input logic [7:0] poly_lo);
      gf8_tbl_t a;
      gf8_tbl_t t;
      a = gf8_alog_tbl(poly_lo);
      t = '0;
      t[8'h00] = 8'hFF;
      for (int k = 0; k < GF8_ORDER; k++) begin
         t[a[k[7:0]]] = k[7:0];
      end
      return t;
   endfunction

endpackage

// File: rtl/gf_power_sweep_8_if.sv
// Control and result bundle of the GF(2^8) table self-test sweep.
interface gf_power_sweep_8_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [7:0] first_err_power;
   logic [7:0] first_err_poly;

   modport slave (
      input  start,
      output busy, done, pass, err_count, first_err_power, first_err_poly
   );

   modport master (
      output start,
      input  busy, done, pass, err_count, first_err_power, first_err_poly
   );
endinterface

// File: rtl/gf_power_sweep_8_mul_alpha.sv
// Combinational GF(2^8) multiply-by-alpha; one step of the reference LFSR.
module gf8_mul_alpha
   import gf8_pkg::*;
#(
   parameter logic [8:0] PRIM_POLY = GF8_PRIM_POLY
) (
   input  logic [7:0] e_i,
   output logic [7:0] e_o
);
   assign e_o = gf8_mul_alpha_f(e_i, PRIM_POLY[7:0]);
endmodule

// File: rtl/gf_power_sweep_8_tables.sv
// GF(2^8) antilog (power->poly) and log (poly->power) lookup ROMs, combinational.
// Both are built from the package primitive polynomial at elaboration.
module gf_power2poly_8
   import gf8_pkg::*;
(
   input  logic [7:0] power_i,
   output logic [7:0] poly_o
);
   localparam gf8_tbl_t ALOG = gf8_alog_tbl(GF8_PRIM_POLY[7:0]);

   assign poly_o = ALOG[power_i];
endmodule

module gf_poly2power_8
   import gf8_pkg::*;
(
   input  logic [7:0] poly_i,
   output logic [7:0] power_o
);
   localparam gf8_tbl_t LOG = gf8_log_tbl(GF8_PRIM_POLY[7:0]);

   assign power_o = LOG[poly_i];
endmodule

// File: rtl/gf_power_sweep_8.sv
// Built-in self test for the GF(2^8) tables: power->poly->power round trip plus an
// independent LFSR cross-check of every antilog entry; one check stage behind the issue.
module gf_power_sweep_8
   import gf8_pkg::*;
#(
   parameter logic [8:0] PRIM_POLY = GF8_PRIM_POLY
) (
   input  logic               clk,
   input  logic               reset_,
   gf_power_sweep_8_if.slave  sw
);

   sweep_state_t state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [7:0]   lfsr_q, lfsr_d;
   logic         v_p1_q, v_p1_d;
   logic [7:0]   poly_p1_q, power_p1_q, exp_p1_q;
   logic [7:0]   err_cnt_q, err_cnt_d;
   logic [7:0]   fep_q, fep_d;
   logic [7:0]   fpoly_q, fpoly_d;
   logic         pass_q, pass_d;

   logic         clear;
   logic         chk_fail;
   logic [7:0]   tbl_poly;
   logic [7:0]   chk_power;
   logic [7:0]   lfsr_nxt;

   gf_power2poly_8 u_p2p (.power_i(cnt_q),     .poly_o(tbl_poly));
   gf_poly2power_8 u_p2w (.poly_i(poly_p1_q),  .power_o(chk_power));
   gf8_mul_alpha #(.PRIM_POLY(PRIM_POLY)) u_alpha (.e_i(lfsr_q), .e_o(lfsr_nxt));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      v_p1_d  = 1'b0;
      clear   = 1'b0;
      case (state_q)
         IDLE: begin
            if (sw.start) begin
               state_d = RUN;
               cnt_d   = 8'd0;
               lfsr_d  = 8'h01;
               clear   = 1'b1;
            end
         end
         RUN: begin
            v_p1_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            lfsr_d = lfsr_nxt;
            if (cnt_q == 8'(GF8_ORDER - 1)) state_d = DRAIN;
         end
         DRAIN:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // A power failing both checks is still a single error.
   assign chk_fail = v_p1_q && ((chk_power != power_p1_q) || (poly_p1_q != exp_p1_q));

   always_comb begin
      err_cnt_d = err_cnt_q;
      fep_d     = fep_q;
      fpoly_d   = fpoly_q;
      pass_d    = pass_q;
      if (clear) begin
         err_cnt_d = 8'd0;
         fep_d     = 8'hFF;
         fpoly_d   = 8'h00;
         pass_d    = 1'b0;
      end else if (chk_fail) begin
         err_cnt_d = err_cnt_q + 8'd1;
         if (err_cnt_q == 8'd0) begin
            fep_d   = power_p1_q;
            fpoly_d = poly_p1_q;
         end
      end
      // Resolved while the last check retires so pass is already valid with done.
      if (state_q == DRAIN) pass_d = (err_cnt_d == 8'd0);
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         lfsr_q     <= 8'h01;
         v_p1_q     <= 1'b0;
         poly_p1_q  <= 8'h00;
         power_p1_q <= 8'h00;
         exp_p1_q   <= 8'h00;
         err_cnt_q  <= 8'd0;
         fep_q      <= 8'hFF;
         fpoly_q    <= 8'h00;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lfsr_q     <= lfsr_d;
         v_p1_q     <= v_p1_d;
         poly_p1_q  <= tbl_poly;
         power_p1_q <= cnt_q;
         exp_p1_q   <= lfsr_q;
         err_cnt_q  <= err_cnt_d;
         fep_q      <= fep_d;
         fpoly_q    <= fpoly_d;
         pass_q     <= pass_d;
      end
   end

   assign sw.busy            = (state_q == RUN) || (state_q == DRAIN);
   assign sw.done            = (state_q == DONE);
   assign sw.pass            = pass_q;
   assign sw.err_count       = err_cnt_q;
   assign sw.first_err_power = fep_q;
   assign sw.first_err_poly  = fpoly_q;

endmodule

// File: tb/tb_gf_power_sweep_8.sv
// Scoreboarded bench: each accepted start queues the model's sweep result, a negedge monitor checks it at done.
module tb_gf_power_sweep_8;

   logic clk = 1'b0;
   logic reset_;
   always #5 clk = ~clk;

   gf_power_sweep_8_if sw_a();
   gf_power_sweep_8_if sw_b();
   assign sw_b.start = sw_a.start;

   gf_power_sweep_8 dut_a (.clk(clk), .reset_(reset_), .sw(sw_a));
   gf_power_sweep_8 #(.PRIM_POLY(9'h12B)) dut_b (.clk(clk), .reset_(reset_), .sw(sw_b));

   typedef struct {
      int pass;
      int cnt;
      int fpow;
      int fpoly;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb, last_a;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cyc[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: table is alpha^k under 0x11D, checked against alpha^k under prim and a log lookup.
   function automatic exp_t model(input int prim, input int inj);
      int   alog[255];
      int   v, rv, t, lg, first;
      exp_t r;
      v = 1;
      for (int k = 0; k < 255; k++) begin
         alog[k] = v;
         v = v * 2;
         if (v > 255) v = v ^ 32'h11D;
      end
      r.cnt = 0; r.fpow = 255; r.fpoly = 0;
      first = 1;
      rv = 1;
      for (int k = 0; k < 255; k++) begin
         t  = (k == inj) ? 0 : alog[k];
         lg = 255;
         for (int j = 0; j < 255; j++) if (alog[j] == t) lg = j;
         if (t != rv || lg != k) begin
            r.cnt++;
            if (first) begin r.fpow = k; r.fpoly = t; first = 0; end
         end
         rv = rv * 2;
         if (rv > 255) rv = rv ^ prim;
      end
      r.pass = (r.cnt == 0);
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_ === 1'b1 && sw_a.done) begin
         chk("busy_low_at_done_a", sw_a.busy, 0);
         if (qa.size() == 0) chk("unexpected_done_a", 1, 0);
         else begin
            ea = qa.pop_front();
            chk("pass_a", sw_a.pass, ea.pass);
            chk("err_count_a", sw_a.err_count, ea.cnt);
            chk("first_err_power_a", sw_a.first_err_power, ea.fpow);
            chk("first_err_poly_a", sw_a.first_err_poly, ea.fpoly);
         end
         done_cyc.push_back(cyc);
      end
      if (reset_ === 1'b1 && sw_b.done) begin
         if (qb.size() == 0) chk("unexpected_done_b", 1, 0);
         else begin
            eb = qb.pop_front();
            chk("pass_b", sw_b.pass, eb.pass);
            chk("err_count_b", sw_b.err_count, eb.cnt);
            chk("first_err_power_b", sw_b.first_err_power, eb.fpow);
            chk("first_err_poly_b", sw_b.first_err_poly, eb.fpoly);
         end
      end
   end

   task automatic push_exp(input int inj_a);
      last_a = model(32'h11D, inj_a);
      qa.push_back(last_a);
      qb.push_back(model(32'h12B, -1));
   endtask

   // One sweep with cycle-exact busy/done checks; inj_a >= 0 zeroes that antilog entry in dut_a.
   task automatic sweep(input int inj_a);
      int nb;
      @(negedge clk);
      sw_a.start = 1'b1;
      push_exp(inj_a);
      @(posedge clk);
      #1 sw_a.start = 1'b0;
      nb = 0;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         if (i == inj_a + 1) force dut_a.tbl_poly = 8'h00;
         if (i == inj_a + 2) release dut_a.tbl_poly;
         if (!(sw_a.busy === 1'b1 && sw_a.done === 1'b0)) nb++;
      end
      chk("busy_window", nb, 0);
      @(negedge clk);
      chk("done_at_T257", sw_a.done, 1);
      @(negedge clk);
      chk("done_single_cycle", sw_a.done, 0);
      chk("idle_not_busy", sw_a.busy, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, sw_a.busy, 0);
      chk({tag, "_done"}, sw_a.done, 0);
      chk({tag, "_pass"}, sw_a.pass, 0);
      chk({tag, "_err_count"}, sw_a.err_count, 0);
      chk({tag, "_first_err_power"}, sw_a.first_err_power, 255);
      chk({tag, "_first_err_poly"}, sw_a.first_err_poly, 0);
      chk({tag, "_b_first_err_power"}, sw_b.first_err_power, 255);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, n;
      sw_a.start = 1'b0;
      reset_     = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset_ = 1'b1;

      // Clean sweep, then results must hold over idle cycles.
      sweep(-1);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sw_a.done !== 1'b0 || sw_a.pass !== last_a.pass[0] ||
             sw_a.err_count != last_a.cnt[7:0] || sw_a.first_err_power != last_a.fpow[7:0] ||
             sw_a.first_err_poly != last_a.fpoly[7:0]) bad++;
      end
      chk("idle_hold", bad, 0);
      chk("idle_pass_held", sw_a.pass, 1);

      // Single fault at power 200 fails both checks but counts once.
      sweep(200);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      sweep(0);
      for (int r = 0; r < 2; r++) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         sweep($urandom_range(0, 254));
      end
      sweep(254);

      // Reset mid-sweep: reset_ low at the edge closing cycle T+100.
      @(negedge clk);
      sw_a.start = 1'b1;
      push_exp(-1);
      @(posedge clk);
      #1 sw_a.start = 1'b0;
      repeat (100) @(negedge clk);
      reset_ = 1'b0;
      void'(qa.pop_back());
      void'(qb.pop_back());
      @(negedge clk);
      check_reset_vals("midreset");
      reset_ = 1'b1;
      repeat (300) @(negedge clk);
      sweep(-1);

      // start held high: accepted at T, T+258, T+516 only.
      done_cyc.delete();
      @(negedge clk);
      sw_a.start = 1'b1;
      for (int i = 0; i < 3; i++) push_exp(-1);
      repeat (600) @(negedge clk);
      sw_a.start = 1'b0;
      n = 0;
      while (done_cyc.size() < 3 && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (300) @(negedge clk);
      chk("held_start_done_count", done_cyc.size(), 3);
      if (done_cyc.size() >= 3) begin
         chk("done_period_1", done_cyc[1] - done_cyc[0], 258);
         chk("done_period_2", done_cyc[2] - done_cyc[1], 258);
      end

      chk("queue_a_drained", qa.size(), 0);
      chk("queue_b_drained", qb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
